regfile_wb_ctrl: RTL

Write-port controller for the 32 x 32-bit register file: it drives the file's D_En, D_Addr and D inputs. It accepts results from a single-cycle ALU source and a handshaked memory-load source, and keeps a scoreboard of destination registers with writes still outstanding. It sits between execute/memory and the register file, and the decode stage queries the scoreboard to stall on RAW/WAW hazards.

---
 rtl/regfile_wb_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Purpose: register-file write-port controller. It arbitrates ALU and load
//          results onto D/D_Addr/D_En and keeps a busy scoreboard for decode.
// Latency: a result selected in cycle N shows D_En/D_Addr/D in N+1. Its busy bit
//          clears at the end of N+1.
// Backpressure: ALU results are never refused. A load is refused (mem_ready low)
//          while the single hold slot is occupied.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   issue_valid/issue_rd/issue_ready    decode claims a destination register
//   alu_valid/alu_rd/alu_data           single-cycle ALU result, always taken
//   mem_valid/mem_rd/mem_data/mem_ready handshaked load result
//   s_addr/t_addr -> s_busy/t_busy      combinational scoreboard queries
//   D_En/D_Addr/D                       registered register-file write port
//   err                                 sticky: result arrived for a non-busy rd
//   wb_count                            committed-write counter, wraps
module regfile_wb_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,

    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,

    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    input  logic [4:0]        s_addr,
    input  logic [4:0]        t_addr,
    output logic              s_busy,
    output logic              t_busy,

    output logic              D_En,
    output logic [4:0]        D_Addr,
    output logic [DATA_W-1:0] D,

    output logic              err,
    output logic [CNT_W-1:0]  wb_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       busy;
    logic [31:0]       busy_nxt;

    logic              hold_valid;
    logic [4:0]        hold_rd;
    logic [DATA_W-1:0] hold_data;

    // Result chosen this cycle
    logic              sel_valid;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              take_hold;
    logic              load_hold;

    logic              issue_fire;
    logic              commit_wr;
    logic              err_set;

    // ------------------------------------------------------------------
    // Scoreboard queries and handshakes
    // ------------------------------------------------------------------
    assign s_busy      = busy[s_addr];
    assign t_busy      = busy[t_addr];

    // r0 is never tracked, so a claim on it is always granted.
    assign issue_ready = ~busy[issue_rd] | (issue_rd == 5'd0);
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != 5'd0);

    assign mem_ready   = ~hold_valid;

    // ------------------------------------------------------------------
    // Result selection: ALU first, then the parked load, then a fresh load.
    // The hold slot exists so a load that collides with an ALU result is
    // still accepted that cycle and drained on the next one.
    // ------------------------------------------------------------------
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = '0;
        take_hold = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (hold_valid) begin
            sel_valid = 1'b1;
            sel_rd    = hold_rd;
            sel_data  = hold_data;
            take_hold = 1'b1;
        end else if (mem_valid & mem_ready) begin
            sel_valid = 1'b1;
            sel_rd    = mem_rd;
            sel_data  = mem_data;
        end
    end

    assign load_hold = alu_valid & mem_valid & mem_ready;

    // Results for r0 are swallowed: no write, no count, no error.
    assign commit_wr = sel_valid & (sel_rd != 5'd0);
    assign err_set   = commit_wr & ~busy[sel_rd];

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear for the register being written now
    // is applied first, so a claim of the same rd on the same edge wins.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        if (D_En) begin
            busy_nxt[D_Addr] = 1'b0;
        end
        if (issue_fire) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Hold slot. A load and a drain cannot happen in the same cycle: a load
    // needs the slot empty, and a drain needs it full with no ALU result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_rd    <= 5'd0;
            hold_data  <= '0;
        end else if (load_hold) begin
            hold_valid <= 1'b1;
            hold_rd    <= mem_rd;
            hold_data  <= mem_data;
        end else if (take_hold) begin
            hold_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write port. Address and data only move on a real write, so D_Addr is
    // never 0 while D_En is high. They keep their last value otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_En   <= 1'b0;
            D_Addr <= 5'd0;
            D      <= '0;
        end else begin
            D_En <= commit_wr;
            if (commit_wr) begin
                D_Addr <= sel_rd;
                D      <= sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky error and a wrapping count of committed writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            wb_count <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            if (D_En) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end

endmodule
